// File: rtl/hazard_ctrl_if.sv
// Hazard controller signal bundle: ID/EX hazard inputs and pipeline-control outputs.
interface hazard_ctrl_if;
  logic [4:0]  id_rs1_addr_i;
  logic [4:0]  id_rs2_addr_i;
  logic [4:0]  ex_rd_addr_i;
  logic        ex_memread_i;
  logic [1:0]  ex_aluop_i;
  logic [6:0]  ex_funct7_i;
  logic        id_branch_i;
  logic        pc_write_o;
  logic        ifid_write_o;
  logic        ifid_flush_o;
  logic        idex_write_o;
  logic        idex_bubble_o;
  logic        exmem_bubble_o;
  logic        mul_start_o;
  logic [15:0] stall_cnt_o;

  // Pipeline side drives hazard inputs and consumes the control outputs.
  modport master (
    output id_rs1_addr_i, id_rs2_addr_i, ex_rd_addr_i, ex_memread_i,
    output ex_aluop_i, ex_funct7_i, id_branch_i,
    input  pc_write_o, ifid_write_o, ifid_flush_o, idex_write_o,
    input  idex_bubble_o, exmem_bubble_o, mul_start_o, stall_cnt_o
  );

  modport slave (
    input  id_rs1_addr_i, id_rs2_addr_i, ex_rd_addr_i, ex_memread_i,
    input  ex_aluop_i, ex_funct7_i, id_branch_i,
    output pc_write_o, ifid_write_o, ifid_flush_o, idex_write_o,
    output idex_bubble_o, exmem_bubble_o, mul_start_o, stall_cnt_o
  );
endinterface

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: multi-cycle multiply stall, load-use stall, branch flush.
// Multiply support is compiled in only when HAZARD_MUL_EN is defined.
module hazard_ctrl (
  input logic          clk_i,
  input logic          rst_i,
  hazard_ctrl_if.slave hz
);

  typedef enum logic [0:0] {StRun, StMulBusy} state_e;

  state_e      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [15:0] stall_cnt_q, stall_cnt_d;

  logic ex_mul;
  logic load_use;
  logic pc_write, ifid_write, ifid_flush, idex_write;
  logic idex_bubble, exmem_bubble, mul_start;

`ifdef HAZARD_MUL_EN
  assign ex_mul = (hz.ex_aluop_i == 2'b10) && (hz.ex_funct7_i == 7'b0000001);
`else
  // Without the multiplier the FSM never leaves StRun.
  assign ex_mul = 1'b0;
  logic unused_mul;
  assign unused_mul = ^{hz.ex_aluop_i, hz.ex_funct7_i};
`endif

  assign load_use = hz.ex_memread_i && (hz.ex_rd_addr_i != 5'd0) &&
                    ((hz.ex_rd_addr_i == hz.id_rs1_addr_i) ||
                     (hz.ex_rd_addr_i == hz.id_rs2_addr_i));

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    pc_write     = 1'b1;
    ifid_write   = 1'b1;
    ifid_flush   = 1'b0;
    idex_write   = 1'b1;
    idex_bubble  = 1'b0;
    exmem_bubble = 1'b0;
    mul_start    = 1'b0;

    case (state_q)
      StRun: begin
        if (ex_mul) begin
          mul_start    = 1'b1;
          pc_write     = 1'b0;
          ifid_write   = 1'b0;
          idex_write   = 1'b0;
          exmem_bubble = 1'b1;
          cnt_d        = 3'd3;
          state_d      = StMulBusy;
        end else if (load_use) begin
          pc_write    = 1'b0;
          ifid_write  = 1'b0;
          idex_bubble = 1'b1;
        end else if (hz.id_branch_i) begin
          ifid_flush = 1'b1;
        end
      end
      StMulBusy: begin
        // ID is frozen here; its hazards are re-evaluated once back in StRun.
        pc_write     = 1'b0;
        ifid_write   = 1'b0;
        idex_write   = 1'b0;
        exmem_bubble = 1'b1;
        cnt_d        = cnt_q - 3'd1;
        if (cnt_q == 3'd1) begin
          state_d = StRun;
        end
      end
      default: state_d = StRun;
    endcase

    // Outputs sit at their idle values while reset is held, whatever the inputs.
    if (!rst_i) begin
      pc_write     = 1'b1;
      ifid_write   = 1'b1;
      ifid_flush   = 1'b0;
      idex_write   = 1'b1;
      idex_bubble  = 1'b0;
      exmem_bubble = 1'b0;
      mul_start    = 1'b0;
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (!pc_write && (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_d = stall_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q     <= StRun;
      cnt_q       <= 3'd0;
      stall_cnt_q <= 16'd0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign hz.pc_write_o     = pc_write;
  assign hz.ifid_write_o   = ifid_write;
  assign hz.ifid_flush_o   = ifid_flush;
  assign hz.idex_write_o   = idex_write;
  assign hz.idex_bubble_o  = idex_bubble;
  assign hz.exmem_bubble_o = exmem_bubble;
  assign hz.mul_start_o    = mul_start;
  assign hz.stall_cnt_o    = stall_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed corner cases plus random stimulus
// against a cycle-level reference model; follows HAZARD_MUL_EN like the design.
module tb_hazard_ctrl;

`ifdef HAZARD_MUL_EN
  localparam bit MulEn = 1'b1;
`else
  localparam bit MulEn = 1'b0;
`endif

  // Output vector order: pc_write, ifid_write, ifid_flush, idex_write,
  // idex_bubble, exmem_bubble, mul_start.
  localparam logic [6:0] OutIdle   = 7'b1101000;
  localparam logic [6:0] OutFlush  = 7'b1111000;
  localparam logic [6:0] OutLoadUs = 7'b0001100;
  localparam logic [6:0] OutMulGo  = 7'b0000011;
  localparam logic [6:0] OutMulBsy = 7'b0000010;

  logic clk_i;
  logic rst_i;

  hazard_ctrl_if hz ();

  hazard_ctrl dut (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .hz    (hz)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  int checks;
  int errors;
  int busy_left;   // remaining multiply stall cycles after the start cycle
  int exp_cnt;

  function automatic logic [6:0] outs();
    return {hz.pc_write_o, hz.ifid_write_o, hz.ifid_flush_o, hz.idex_write_o,
            hz.idex_bubble_o, hz.exmem_bubble_o, hz.mul_start_o};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [4:0] a1, input logic [4:0] a2, input logic [4:0] d,
                       input logic mr, input logic [1:0] op, input logic [6:0] f7,
                       input logic br);
    hz.id_rs1_addr_i = a1;
    hz.id_rs2_addr_i = a2;
    hz.ex_rd_addr_i  = d;
    hz.ex_memread_i  = mr;
    hz.ex_aluop_i    = op;
    hz.ex_funct7_i   = f7;
    hz.id_branch_i   = br;
  endtask

  // One clock cycle: apply inputs, check against the model mid-cycle, then advance.
  task automatic step(input string tag, input logic [4:0] a1, input logic [4:0] a2,
                      input logic [4:0] d, input logic mr, input logic [1:0] op,
                      input logic [6:0] f7, input logic br);
    logic [6:0] exp_o;
    bit         mul;
    bit         lu;
    drive(a1, a2, d, mr, op, f7, br);
    #4;
    mul = MulEn && (op == 2'b10) && (f7 == 7'd1);
    lu  = mr && (d != 5'd0) && ((d == a1) || (d == a2));
    if (busy_left > 0)  exp_o = OutMulBsy;
    else if (mul)       exp_o = OutMulGo;
    else if (lu)        exp_o = OutLoadUs;
    else if (br)        exp_o = OutFlush;
    else                exp_o = OutIdle;
    check({tag, "_outs"}, {25'd0, outs()}, {25'd0, exp_o});
    check({tag, "_stall_cnt"}, {16'd0, hz.stall_cnt_o}, exp_cnt);
    @(posedge clk_i);
    if (!exp_o[6] && exp_cnt < 65535) exp_cnt++;
    if (busy_left > 0) busy_left--;
    else if (mul) busy_left = 3;
    #1;
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    busy_left = 0;
    exp_cnt   = 0;
    rst_i     = 1'b0;
    // Hazard-looking inputs during reset must not reach the outputs.
    drive(5'd5, 5'd0, 5'd5, 1'b1, 2'b10, 7'd1, 1'b1);
    #2;
    check("reset_outs", {25'd0, outs()}, {25'd0, OutIdle});
    check("reset_stall_cnt", {16'd0, hz.stall_cnt_o}, 32'd0);
    drive(5'd0, 5'd0, 5'd0, 1'b0, 2'b00, 7'd0, 1'b0);
    #10 rst_i = 1'b1;
    @(posedge clk_i);
    #1;

    step("idle", 5'd1, 5'd2, 5'd3, 1'b0, 2'b00, 7'd0, 1'b0);
    // Load-use on rs2 stalls exactly one cycle.
    step("load_use", 5'd0, 5'd5, 5'd5, 1'b1, 2'b00, 7'd0, 1'b0);
    check("load_use_cnt", {16'd0, hz.stall_cnt_o}, 32'd1);
    step("after_lu", 5'd0, 5'd5, 5'd7, 1'b0, 2'b00, 7'd0, 1'b0);
    // Loads into x0 never stall.
    step("x0", 5'd0, 5'd3, 5'd0, 1'b1, 2'b00, 7'd0, 1'b0);
    step("branch", 5'd1, 5'd2, 5'd3, 1'b0, 2'b00, 7'd0, 1'b1);
    step("lu_vs_br", 5'd4, 5'd2, 5'd4, 1'b1, 2'b00, 7'd0, 1'b1);

    // Multiply with a branch pending in ID: flush waits for the first RUN cycle.
    step("mul_go", 5'd1, 5'd2, 5'd3, 1'b0, 2'b10, 7'd1, 1'b1);
    for (int i = 0; i < 3; i++) step("mul_busy", 5'd1, 5'd2, 5'd3, 1'b0, 2'b00, 7'd0, 1'b1);
    step("mul_done", 5'd1, 5'd2, 5'd3, 1'b0, 2'b00, 7'd0, 1'b1);
    check("mul_stall_cnt", {16'd0, hz.stall_cnt_o}, MulEn ? 32'd6 : 32'd2);

    // Reset in the middle of a multiply sequence.
    step("mul2_go", 5'd1, 5'd2, 5'd3, 1'b0, 2'b10, 7'd1, 1'b0);
    step("mul2_busy", 5'd1, 5'd2, 5'd3, 1'b0, 2'b00, 7'd0, 1'b0);
    drive(5'd6, 5'd0, 5'd6, 1'b1, 2'b10, 7'd1, 1'b1);
    rst_i = 1'b0;
    #1;
    check("midrst_outs", {25'd0, outs()}, {25'd0, OutIdle});
    check("midrst_stall_cnt", {16'd0, hz.stall_cnt_o}, 32'd0);
    busy_left = 0;
    exp_cnt   = 0;
    drive(5'd0, 5'd0, 5'd0, 1'b0, 2'b00, 7'd0, 1'b0);
    @(posedge clk_i);
    #2 rst_i = 1'b1;
    step("post_rst", 5'd1, 5'd2, 5'd3, 1'b0, 2'b00, 7'd0, 1'b0);
    step("post_rst2", 5'd1, 5'd2, 5'd3, 1'b0, 2'b00, 7'd0, 1'b0);

    // Random traffic biased toward register collisions and multiplies.
    for (int i = 0; i < 400; i++) begin
      logic [1:0] op;
      logic [6:0] f7;
      if ($urandom_range(0, 5) == 0) begin
        op = 2'b10;
        f7 = 7'd1;
      end else begin
        op = 2'($urandom_range(0, 3));
        f7 = ($urandom_range(0, 1) == 1) ? 7'd1 : 7'h20;
      end
      step("rand", 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
           5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), op, f7,
           1'($urandom_range(0, 1)));
    end

    // Drive the stall counter into saturation.
    for (int i = 0; i < 65540; i++) step("sat", 5'd9, 5'd1, 5'd9, 1'b1, 2'b00, 7'd0, 1'b0);
    check("sat_hold", {16'd0, hz.stall_cnt_o}, 32'hFFFF);
    step("sat_idle", 5'd1, 5'd2, 5'd3, 1'b0, 2'b00, 7'd0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 SHALL have port clk_i  input  1  single clock, rising edge.
REQ-002 SHALL have port rst_i  input  1  asynchronous reset, active-low.
REQ-003 SHALL have port id_rs1_addr_i  input  5  rs1 of instruction in ID.
REQ-004 SHALL have port id_rs2_addr_i  input  5  rs2 of instruction in ID.
REQ-005 SHALL have port ex_rd_addr_i  input  5  rd of instruction in EX.
REQ-006 SHALL have port ex_memread_i  input  1  EX instruction is a load (Mem[1]).
REQ-007 SHALL have port ex_aluop_i  input  2  ALUOp of EX instruction.
REQ-008 SHALL have port ex_funct7_i  input  7  funct7 of EX instruction.
REQ-009 SHALL have port id_branch_i  input  1  branch in ID resolved taken.
REQ-010 SHALL have port pc_write_o  output  1  PC update enable.
REQ-011 SHALL have port ifid_write_o  output  1  IF/ID register load enable.
REQ-012 SHALL have port ifid_flush_o  output  1  zero IF/ID on next edge.
REQ-013 SHALL have port idex_write_o  output  1  ID/EX register load enable.
REQ-014 SHALL have port idex_bubble_o  output  1  load NOP controls into ID/EX.
REQ-015 SHALL have port exmem_bubble_o  output  1  load NOP controls into EX/MEM.
REQ-016 SHALL have port mul_start_o  output  1  one-cycle multiplier start pulse.
REQ-017 SHALL have port stall_cnt_o  output  16  stall-cycle counter.

Function
REQ-018 SHALL implement FSM states RUN, MUL_BUSY; reset state RUN.
REQ-019 SHALL flag ex_mul when ex_aluop_i==2'b10 and ex_funct7_i==7'b0000001.
REQ-020 SHALL, in RUN with ex_mul, pulse mul_start_o, load 3-bit cnt=3, enter MUL_BUSY.
REQ-021 SHALL, in MUL_BUSY, decrement cnt each cycle; return to RUN on edge where cnt==1; total EX occupancy 4 cycles.
REQ-022 SHALL, during the entry cycle and all MUL_BUSY cycles, drive pc_write_o=0, ifid_write_o=0, idex_write_o=0, exmem_bubble_o=1; exmem_bubble_o=0 in the cycle the FSM is back in RUN.
REQ-023 SHALL detect load-use in RUN when ex_memread_i=1, ex_rd_addr_i!=0, and ex_rd_addr_i equals id_rs1_addr_i or id_rs2_addr_i.
REQ-024 SHALL on load-use drive pc_write_o=0, ifid_write_o=0, idex_bubble_o=1 for exactly that cycle.
REQ-025 SHALL on id_branch_i in RUN with no stall drive ifid_flush_o=1 that cycle; PC unaffected.
REQ-026 SHALL apply priority multiply stall > load-use > branch flush; lower-priority outputs deasserted while higher active.
REQ-027 SHALL ignore id_branch_i and load-use during multiply stall (ID held, re-evaluated on RUN).
REQ-028 SHALL, with no hazard, drive pc_write_o=1, ifid_write_o=1, idex_write_o=1, all bubble/flush/start outputs 0.
REQ-029 SHALL increment stall_cnt_o once per cycle with pc_write_o=0, saturating at 16'hFFFF.
REQ-030 SHALL drive all outputs other than stall_cnt_o combinationally from state, cnt and inputs.

Reset
REQ-031 SHALL on rst_i=0 force state RUN, cnt=0, stall_cnt_o=0 immediately, independent of clk_i.
REQ-032 SHALL during reset drive pc_write_o=1, ifid_write_o=1, idex_write_o=1, other 1-bit outputs 0.
REQ-033 SHALL on reset mid-multiply abandon the sequence; no mul_start_o until a new ex_mul is seen after release.

Configuration
REQ-034 SHALL with HAZARD_MUL_EN defined implement REQ-019..REQ-022 and REQ-027.
REQ-035 SHALL without HAZARD_MUL_EN tie mul_start_o=0, exmem_bubble_o=0, idex_write_o=1, remain in RUN.

Verification
REQ-036 SHALL cover load-use: ex_memread_i=1, ex_rd=5, id_rs2=5 -> one cycle pc_write_o=0, idex_bubble_o=1, stall_cnt_o 0->1.
REQ-037 SHALL cover x0: ex_memread_i=1, ex_rd=0, id_rs1=0 -> no stall.
REQ-038 SHALL cover multiply: aluop=10, funct7=0000001 -> mul_start_o one cycle, 4 stall cycles, stall_cnt_o=4, then RUN.
REQ-039 SHALL cover priority: multiply plus id_branch_i=1 -> ifid_flush_o=0 during stall, flush on first RUN cycle if branch still asserted.
REQ-040 SHALL cover reset mid-multiply: rst_i=0 at cnt=2 -> outputs at reset values asynchronously, stall_cnt_o=0.
REQ-041 SHALL cover saturation: force 65535 stalls -> stall_cnt_o holds 16'hFFFF.
